// File: rtl/sta_operand_feeder.sv
// Operand injector for the 4x4 systolic tensor array: diagonal skew, stall, pe_mask and done.
// Define STA_FEEDER_BIAS_EN to build the first-flag chain that drives the per-PE load_bias wavefront.
module sta_operand_feeder #(
  parameter int N            = 4,
  parameter int VECTOR_WIDTH = 4,
  parameter int K_W          = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [K_W-1:0]                       k_steps,
  input  logic [2:0]                           rows_active,
  input  logic [2:0]                           cols_active,
  input  logic                                 op_valid,
  input  logic [N-1:0][VECTOR_WIDTH-1:0][7:0]  op_a,
  input  logic [N-1:0][VECTOR_WIDTH-1:0][7:0]  op_b,
  output logic                                 op_ready,
  output logic [VECTOR_WIDTH-1:0][7:0]         A0,
  output logic [VECTOR_WIDTH-1:0][7:0]         A1,
  output logic [VECTOR_WIDTH-1:0][7:0]         A2,
  output logic [VECTOR_WIDTH-1:0][7:0]         A3,
  output logic [VECTOR_WIDTH-1:0][7:0]         B0,
  output logic [VECTOR_WIDTH-1:0][7:0]         B1,
  output logic [VECTOR_WIDTH-1:0][7:0]         B2,
  output logic [VECTOR_WIDTH-1:0][7:0]         B3,
  output logic [N-1:0]                         load_bias0,
  output logic [N-1:0]                         load_bias1,
  output logic [N-1:0]                         load_bias2,
  output logic [N-1:0]                         load_bias3,
  output logic [N*N-1:0]                       pe_mask,
  output logic                                 stall,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [VECTOR_WIDTH-1:0][7:0] vec_t;

  localparam int                DRAIN_W    = $clog2(2*N);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2*N-2);

  state_t                              state, state_n;
  logic                                xfer;
  logic                                last_xfer;
  logic [K_W-1:0]                      k_lat;
  logic [K_W-1:0]                      k_cnt;
  logic [DRAIN_W-1:0]                  drain_cnt;
  logic [2:0]                          rows_eff;
  logic [2:0]                          cols_eff;
  logic [N*N-1:0]                      mask_n;
  logic [N-1:0][VECTOR_WIDTH-1:0][7:0] a_s0;
  logic [N-1:0][VECTOR_WIDTH-1:0][7:0] b_s0;
  vec_t                                a_out [N];
  vec_t                                b_out [N];
  logic [N-1:0][N-1:0]                 lb;

  // Handshake: a transfer happens in any cycle where op_valid & op_ready; op_ready
  // is high only in FEED and never depends on op_valid, so the source may hold data.
  assign xfer      = op_valid & op_ready;
  assign last_xfer = (k_cnt == k_lat - 1'b1);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    op_ready = 1'b0;
    stall    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = (k_steps == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        op_ready = 1'b1;
        stall    = ~op_valid;
        if (op_valid && last_xfer) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Counts clamp above N so a too-large rows/cols request simply enables the full array.
  always_comb begin
    rows_eff = (rows_active > 3'(N)) ? 3'(N) : rows_active;
    cols_eff = (cols_active > 3'(N)) ? 3'(N) : cols_active;
    mask_n   = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        mask_n[r*N+c] = (3'(r) < rows_eff) && (3'(c) < cols_eff);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_lat     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      pe_mask   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        k_lat     <= k_steps;
        k_cnt     <= '0;
        drain_cnt <= '0;
        pe_mask   <= mask_n;
      end
      if (xfer)               k_cnt     <= k_cnt + 1'b1;
      if (state == S_DRAIN)   drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Stage 0 carries zeros whenever no operand set is accepted, which flushes the skew.
  assign a_s0     = xfer ? op_a : '0;
  assign b_s0     = xfer ? op_b : '0;
  assign a_out[0] = a_s0[0];
  assign b_out[0] = b_s0[0];

  for (genvar g = 1; g < N; g++) begin : g_skew
    vec_t a_sr [g];
    vec_t b_sr [g];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < g; i++) begin
          a_sr[i] <= '0;
          b_sr[i] <= '0;
        end
      end else if (!stall) begin
        a_sr[0] <= a_s0[g];
        b_sr[0] <= b_s0[g];
        for (int i = 1; i < g; i++) begin
          a_sr[i] <= a_sr[i-1];
          b_sr[i] <= b_sr[i-1];
        end
      end
    end

    assign a_out[g] = a_sr[g-1];
    assign b_out[g] = b_sr[g-1];
  end

  assign A0 = a_out[0];
  assign A1 = a_out[1];
  assign A2 = a_out[2];
  assign A3 = a_out[3];
  assign B0 = b_out[0];
  assign B1 = b_out[1];
  assign B2 = b_out[2];
  assign B3 = b_out[3];

`ifdef STA_FEEDER_BIAS_EN
  logic           first_pend;
  logic [2*N-2:0] chain;
  logic [2*N-2:1] chain_q;

  // chain[d] marks the k=0 operands sitting d skew stages from the array corner.
  assign chain = {chain_q, xfer & first_pend};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_pend <= 1'b0;
      chain_q    <= '0;
    end else begin
      if (state == S_IDLE && start) first_pend <= (k_steps != '0);
      else if (xfer)                first_pend <= 1'b0;
      if (!stall) chain_q <= {chain_q[2*N-3:1], chain[0]};
    end
  end

  always_comb begin
    lb = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        lb[r][c] = chain[r+c] & pe_mask[r*N+c];
      end
    end
  end
`else
  assign lb = '0;
`endif

  assign load_bias0 = lb[0];
  assign load_bias1 = lb[1];
  assign load_bias2 = lb[2];
  assign load_bias3 = lb[3];

endmodule
